// File: rtl/prbs_chk_if.sv
// Stream and status bundle between a PRBS source/monitor and the prbs_chk checker.
interface prbs_chk_if #(
    parameter int ERR_CNT_W = 32
);
    logic                 clear;
    logic                 din_valid;
    logic                 din;
    logic                 locked;
    logic                 err_pulse;
    logic [ERR_CNT_W-1:0] err_cnt;
    logic [ERR_CNT_W-1:0] bit_cnt;

    modport master (
        output clear, din_valid, din,
        input  locked, err_pulse, err_cnt, bit_cnt
    );

    modport slave (
        input  clear, din_valid, din,
        output locked, err_pulse, err_cnt, bit_cnt
    );
endinterface

// File: rtl/prbs_chk.sv
// Self-synchronising serial PRBS checker with flywheel prediction and loss-of-lock detection.
// Define PRBS_CHK_BIT_CNT_EN to implement the checked-bit counter on bit_cnt.
module prbs_chk #(
    parameter int              WIDTH       = 16,
    parameter logic [WIDTH-1:0] POLY       = 16'h6801,
    parameter int              SYNC_CNT    = 16,
    parameter int              WIN         = 64,
    parameter int              LOSS_THRESH = 8,
    parameter int              ERR_CNT_W   = 32
) (
    input  logic      clk,
    input  logic      rst,
    prbs_chk_if.slave bus
);
    localparam logic [WIDTH-1:0] TAPS = POLY >> 1;
    localparam int FILL_W = $clog2(WIDTH + 1);
    localparam int WC_W   = $clog2(WIN);
    localparam int WE_W   = $clog2(WIN + 1);

    typedef enum logic {SEARCH, LOCKED} state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     sr_q, sr_d;
    logic [FILL_W-1:0]    fill_q, fill_d;
    logic [7:0]           match_q, match_d;
    logic [WC_W-1:0]      win_cnt_q, win_cnt_d;
    logic [WE_W-1:0]      win_err_q, win_err_d;
    logic [WE_W-1:0]      win_base, win_err_nxt;
    logic                 err_pulse_q, err_pulse_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                 exp_bit, err_bit;

    assign exp_bit = (^(sr_q & TAPS)) ^ sr_q[WIDTH-1];
    assign err_bit = bus.din ^ exp_bit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SEARCH;
            sr_q        <= '0;
            fill_q      <= '0;
            match_q     <= '0;
            win_cnt_q   <= '0;
            win_err_q   <= '0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            win_cnt_q   <= win_cnt_d;
            win_err_q   <= win_err_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    // An error on the window's last bit opens the next window rather than closing this one.
    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        fill_d      = fill_q;
        match_d     = match_q;
        win_cnt_d   = win_cnt_q;
        win_err_d   = win_err_q;
        err_pulse_d = 1'b0;
        err_cnt_d   = err_cnt_q;
        win_base    = (win_cnt_q == WC_W'(WIN - 1)) ? '0 : win_err_q;
        win_err_nxt = win_base + WE_W'(err_bit);

        if (bus.din_valid) begin
            if (state_q == SEARCH) begin
                sr_d = {sr_q[WIDTH-2:0], bus.din};
                if (fill_q != FILL_W'(WIDTH)) begin
                    fill_d = fill_q + 1'b1;
                end else if (sr_q == '0) begin
                    match_d = '0;
                end else if (!err_bit) begin
                    if (match_q == 8'(SYNC_CNT - 1)) begin
                        state_d   = LOCKED;
                        match_d   = '0;
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end else begin
                        match_d = match_q + 1'b1;
                    end
                end else begin
                    match_d = '0;
                end
            end else begin
                sr_d      = {sr_q[WIDTH-2:0], exp_bit};
                win_cnt_d = win_cnt_q + 1'b1;
                win_err_d = win_err_nxt;
                if (err_bit) begin
                    err_pulse_d = 1'b1;
                    if (err_cnt_q != '1) begin
                        err_cnt_d = err_cnt_q + 1'b1;
                    end
                    if (win_err_nxt == WE_W'(LOSS_THRESH)) begin
                        state_d   = SEARCH;
                        fill_d    = '0;
                        match_d   = '0;
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end
                end
            end
        end

        if (bus.clear) begin
            err_cnt_d = '0;
        end
    end

    assign bus.locked    = (state_q == LOCKED);
    assign bus.err_pulse = err_pulse_q;
    assign bus.err_cnt   = err_cnt_q;

`ifdef PRBS_CHK_BIT_CNT_EN
    logic [ERR_CNT_W-1:0] bit_cnt_q;

    always_ff @(posedge clk) begin
        if (rst || bus.clear) begin
            bit_cnt_q <= '0;
        end else if (bus.din_valid && state_q == LOCKED && bit_cnt_q != '1) begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
        end
    end

    assign bus.bit_cnt = bit_cnt_q;
`else
    assign bus.bit_cnt = '0;
`endif
endmodule

// File: tb/tb_prbs_chk.sv
// Directed self-checking bench for prbs_chk: a default checker (A) and a 4-bit-counter,
// no-loss variant (B) fed from a Fibonacci generator model seeded with 16'hACE1.
module tb_prbs_chk;
    localparam logic [15:0] POLY = 16'h6801;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [15:0] gen;
    int total = 0;
    int bad = 0;

    prbs_chk_if #(.ERR_CNT_W(32)) bus_a();
    prbs_chk_if #(.ERR_CNT_W(4))  bus_b();

    prbs_chk #(.WIDTH(16), .POLY(POLY), .SYNC_CNT(16), .WIN(64), .LOSS_THRESH(8), .ERR_CNT_W(32))
        dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    prbs_chk #(.WIDTH(16), .POLY(POLY), .SYNC_CNT(16), .WIN(64), .LOSS_THRESH(64), .ERR_CNT_W(4))
        dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    always #5 clk = ~clk;

    // Generator model: the feedback bit is both the serial output and the new bit 0.
    task automatic nextBit(output logic b);
        b = (^(gen & (POLY >> 1))) ^ gen[15];
        gen = {gen[14:0], b};
    endtask

    task automatic applyStimulus(input int unit, input logic vld, input logic b, input logic clr);
        bus_a.din_valid = (unit == 0) ? vld : 1'b0;
        bus_a.din       = (unit == 0) ? b   : 1'b0;
        bus_a.clear     = (unit == 0) ? clr : 1'b0;
        bus_b.din_valid = (unit == 1) ? vld : 1'b0;
        bus_b.din       = (unit == 1) ? b   : 1'b0;
        bus_b.clear     = (unit == 1) ? clr : 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(0, 1'b0, 1'b0, 1'b0);
        applyStimulus(0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        gen = SEED;
    endtask

    initial begin
        logic b;
        int cnt;
        int valid_bits;

        // Reset state
        doReset();
        checkOutput("rst_locked", 64'(bus_a.locked), 64'd0);
        checkOutput("rst_err_pulse", 64'(bus_a.err_pulse), 64'd0);
        checkOutput("rst_err_cnt", 64'(bus_a.err_cnt), 64'd0);
        checkOutput("rst_bit_cnt", 64'(bus_a.bit_cnt), 64'd0);

        // Clean stream: 16 fill bits + 16 matches, so lock on valid bit 32
        cnt = 0;
        for (int i = 1; i <= 200; i++) begin
            nextBit(b);
            applyStimulus(0, 1'b1, b, 1'b0);
            if (bus_a.err_pulse) cnt++;
            if (i == 31) checkOutput("clean_unlocked_31", 64'(bus_a.locked), 64'd0);
            if (i == 32) checkOutput("clean_locked_32", 64'(bus_a.locked), 64'd1);
        end
        checkOutput("clean_no_pulse", 64'(cnt), 64'd0);
        checkOutput("clean_err_cnt", 64'(bus_a.err_cnt), 64'd0);
`ifdef PRBS_CHK_BIT_CNT_EN
        checkOutput("clean_bit_cnt", 64'(bus_a.bit_cnt), 64'd168);
`else
        checkOutput("clean_bit_cnt", 64'(bus_a.bit_cnt), 64'd0);
`endif

        // Single inverted bit while locked: flywheel gives exactly one error
        nextBit(b);
        applyStimulus(0, 1'b1, ~b, 1'b0);
        checkOutput("single_pulse", 64'(bus_a.err_pulse), 64'd1);
        checkOutput("single_err_cnt", 64'(bus_a.err_cnt), 64'd1);
        checkOutput("single_locked", 64'(bus_a.locked), 64'd1);
        cnt = 0;
        for (int i = 1; i <= 40; i++) begin
            nextBit(b);
            applyStimulus(0, 1'b1, b, 1'b0);
            if (i == 1) checkOutput("single_pulse_width", 64'(bus_a.err_pulse), 64'd0);
            if (bus_a.err_pulse) cnt++;
        end
        checkOutput("single_no_more_errs", 64'(cnt), 64'd0);
        checkOutput("single_err_cnt_hold", 64'(bus_a.err_cnt), 64'd1);
        checkOutput("single_still_locked", 64'(bus_a.locked), 64'd1);

        // Loss of lock: fresh lock, then 8 bad bits inside the first window
        doReset();
        for (int i = 1; i <= 32; i++) begin
            nextBit(b);
            applyStimulus(0, 1'b1, b, 1'b0);
        end
        checkOutput("loss_prelock", 64'(bus_a.locked), 64'd1);
        for (int k = 1; k <= 8; k++) begin
            nextBit(b);
            applyStimulus(0, 1'b1, ~b, 1'b0);
            if (k == 7) checkOutput("loss_hold_at_7", 64'(bus_a.locked), 64'd1);
            if (k == 7) checkOutput("loss_err_cnt_7", 64'(bus_a.err_cnt), 64'd7);
        end
        checkOutput("loss_drop_at_8", 64'(bus_a.locked), 64'd0);
        checkOutput("loss_err_cnt_8", 64'(bus_a.err_cnt), 64'd8);
        checkOutput("loss_pulse_8", 64'(bus_a.err_pulse), 64'd1);
        for (int i = 1; i <= 32; i++) begin
            nextBit(b);
            applyStimulus(0, 1'b1, b, 1'b0);
            if (i == 31) checkOutput("relock_not_yet", 64'(bus_a.locked), 64'd0);
        end
        checkOutput("relock_at_32", 64'(bus_a.locked), 64'd1);
        checkOutput("relock_err_cnt", 64'(bus_a.err_cnt), 64'd8);

        // Search disruption at bit 25: the bad bit sits in sr and corrupts the
        // predictions as it crosses taps 10,12,13,15 (bits 36,38,39,41), so the
        // last mismatch is bit 41 and 16 matches later lock lands on bit 57.
        doReset();
        for (int i = 1; i <= 60; i++) begin
            nextBit(b);
            applyStimulus(0, 1'b1, (i == 25) ? ~b : b, 1'b0);
            if (i == 32) checkOutput("disrupt_no_lock_32", 64'(bus_a.locked), 64'd0);
            if (i == 41) checkOutput("disrupt_no_lock_41", 64'(bus_a.locked), 64'd0);
            if (i == 56) checkOutput("disrupt_no_lock_56", 64'(bus_a.locked), 64'd0);
            if (i == 57) checkOutput("disrupt_lock_57", 64'(bus_a.locked), 64'd1);
        end

        // Valid gaps: valid on odd cycles with junk on din otherwise
        doReset();
        cnt = 0;
        valid_bits = 0;
        for (int c = 1; c <= 70; c++) begin
            if (c % 2 == 1) begin
                nextBit(b);
                valid_bits++;
                applyStimulus(0, 1'b1, b, 1'b0);
            end else begin
                applyStimulus(0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
                if (bus_a.err_pulse) cnt++;
            end
            if (c == 62) checkOutput("gaps_unlocked_62", 64'(bus_a.locked), 64'd0);
            if (c == 63) checkOutput("gaps_locked_63", 64'(bus_a.locked), 64'd1);
        end
        checkOutput("gaps_valid_bits", 64'(valid_bits), 64'd35);
        checkOutput("gaps_no_pulse_idle", 64'(cnt), 64'd0);
        checkOutput("gaps_err_cnt", 64'(bus_a.err_cnt), 64'd0);

        // Saturation and clear on checker B (4-bit counter, no loss of lock)
        doReset();
        for (int i = 1; i <= 32; i++) begin
            nextBit(b);
            applyStimulus(1, 1'b1, b, 1'b0);
        end
        checkOutput("sat_locked", 64'(bus_b.locked), 64'd1);
        for (int j = 1; j <= 20; j++) begin
            for (int i = 0; i < 3; i++) begin
                nextBit(b);
                applyStimulus(1, 1'b1, b, 1'b0);
            end
            nextBit(b);
            applyStimulus(1, 1'b1, ~b, 1'b0);
            if (j == 14) checkOutput("sat_err_cnt_14", 64'(bus_b.err_cnt), 64'd14);
        end
        checkOutput("sat_err_cnt_hold", 64'(bus_b.err_cnt), 64'd15);
        checkOutput("sat_still_locked", 64'(bus_b.locked), 64'd1);
        nextBit(b);
        applyStimulus(1, 1'b1, ~b, 1'b1);
        checkOutput("clear_err_cnt", 64'(bus_b.err_cnt), 64'd0);
        checkOutput("clear_err_pulse", 64'(bus_b.err_pulse), 64'd1);
        checkOutput("clear_keeps_lock", 64'(bus_b.locked), 64'd1);

        // All-zero stream must never lock
        doReset();
        cnt = 0;
        for (int i = 1; i <= 100; i++) begin
            applyStimulus(1, 1'b1, 1'b0, 1'b0);
            if (bus_b.locked) cnt++;
        end
        checkOutput("zeros_never_lock", 64'(cnt), 64'd0);

        applyStimulus(0, 1'b0, 1'b0, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
